// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that serialises host reads and writes onto the single
// register port of the GPU register file (en/addr/din/we, dout one cycle
// after en). Reads and writes alternate when both are pending.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | accept AW/W/AR halves into latches, arbitrate latched work
// WR_ISSUE   | one-cycle register write strobe from the latched AW/W
// WR_RESP    | bvalid held until bready
// RD_ISSUE   | one-cycle register read strobe from the latched AR
// RD_CAPTURE | register dout valid this cycle, captured into rdata
// RD_RESP    | rvalid held with stable rdata until rready
module axi_lite_reg_bridge #(
    parameter int ADDR_BITS  = 7,
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_BITS-1:0]    s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [8*DATA_BYTES-1:0] s_axi_wdata,
    input  logic [DATA_BYTES-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_BITS-1:0]    s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [8*DATA_BYTES-1:0] s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    reg_en,
    output logic [ADDR_BITS-1:0]    reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_din,
    output logic [DATA_BYTES-1:0]   reg_we,
    input  logic [8*DATA_BYTES-1:0] reg_dout
);

    localparam int DW = 8 * DATA_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_CAPTURE,
        RD_RESP
    } state_t;

    state_t state, state_nx;

    logic                  aw_held, w_held, ar_held;
    logic                  prio_write;
    logic [ADDR_BITS-1:0]  aw_addr, ar_addr;
    logic [DW-1:0]         w_data;
    logic [DATA_BYTES-1:0] w_strb;
    logic [DW-1:0]         rdata_q;
    logic                  in_idle;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_grant, rd_grant;

    // Readies are gated by rst so nothing handshakes while reset is held.
    assign in_idle       = (state == IDLE) && !rst;
    assign s_axi_awready = in_idle && !aw_held;
    assign s_axi_wready  = in_idle && !w_held;
    assign s_axi_arready = in_idle && !ar_held && !(aw_held && w_held && prio_write);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // Grants act on latched halves only; a pending read steals the port
    // from a complete write when priority has flipped to read.
    assign wr_grant = aw_held && w_held && (prio_write || !ar_held);
    assign rd_grant = ar_held && !wr_grant;

    assign s_axi_bresp  = 2'b00;
    assign s_axi_rresp  = 2'b00;
    assign s_axi_bvalid = (state == WR_RESP);
    assign s_axi_rvalid = (state == RD_RESP);
    assign s_axi_rdata  = rdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wr_grant) begin
                    state_nx = WR_ISSUE;
                end else if (rd_grant) begin
                    state_nx = RD_ISSUE;
                end
            end
            WR_ISSUE:   state_nx = WR_RESP;
            WR_RESP:    if (s_axi_bready) state_nx = IDLE;
            RD_ISSUE:   state_nx = RD_CAPTURE;
            RD_CAPTURE: state_nx = RD_RESP;
            RD_RESP:    if (s_axi_rready) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Register-port drive: only the ISSUE states touch the register file.
    always_comb begin
        reg_en   = 1'b0;
        reg_addr = '0;
        reg_din  = '0;
        reg_we   = '0;
        case (state)
            WR_ISSUE: begin
                reg_en   = 1'b1;
                reg_addr = aw_addr;
                reg_din  = w_data;
                reg_we   = w_strb;
            end
            RD_ISSUE: begin
                reg_en   = 1'b1;
                reg_addr = ar_addr;
            end
            default: ;
        endcase
    end

    // Request latches, arbitration priority and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            ar_held    <= 1'b0;
            prio_write <= 1'b1;
            aw_addr    <= '0;
            ar_addr    <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            rdata_q    <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (ar_hs) begin
                ar_held <= 1'b1;
                ar_addr <= s_axi_araddr;
            end
            if (state == IDLE && wr_grant) begin
                prio_write <= 1'b0;
            end else if (state == IDLE && rd_grant) begin
                prio_write <= 1'b1;
                ar_held    <= 1'b0;
            end
            if (state == WR_ISSUE) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (state == RD_CAPTURE) begin
                rdata_q <= reg_dout;
            end
        end
    end

endmodule
